mul_24bit_seq: RTL
==================

# mul_24bit_seq

Area-reduced sequential mantissa multiplier for the FPU: computes the full 48-bit product of two 24-bit unsigned significands by time-multiplexing a single 8x8 array multiplier over the nine byte-pair partial products, accumulating each into a 48-bit register. It sits between the FP multiply front end (unpack/exponent logic) and normalisation/rounding. It is an alternative to the fully parallel 24x24 array where throughput of one product per ~10 cycles is acceptable. Valid/ready handshakes on both sides.

## Interface
- SKIP_ZERO, 1, when 1 a zero operand bypasses the nine-step sequence (result 0, short latency)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand pair presented
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  24  multiplicand significand, unsigned
- b  in  24  multiplier significand, unsigned
- out_valid  out  1  c holds a completed product
- out_ready  in  1  downstream consumes c
- c  out  48  product a*b, unsigned
- busy  out  1  high in MUL or DONE

## Operation
- States: IDLE, MUL, DONE. Reset state IDLE.
- Accept: in_valid && in_ready at a rising edge latches a, b into operand registers, clears acc, sets step k=0.
  - Normal: -> MUL.
  - SKIP_ZERO=1 and (a==0 or b==0): -> DONE directly, result register loaded with 0.
- MUL, step k = 0..8: i = k/3, j = k%3. One 8x8 multiply of a_reg[8i+7:8i] by b_reg[8j+7:8j]; 16-bit product zero-extended, shifted left 8*(i+j), added to acc (48-bit, modulo 2^48; final sum cannot overflow).
  - k increments each cycle; at k==8 the sum acc+pp is written to the result register, state -> DONE.
- DONE: out_valid=1, c = result register. Stay until out_ready=1; then -> IDLE.
- in_ready = (state==IDLE); no accept in MUL or DONE, even if out_ready is high in the same cycle.
- out_ready ignored outside DONE. a, b ignored except on the accept edge.
- c is driven only from the result register: updated only on entering DONE, otherwise holds the last product. Intermediate acc values never appear on c.
- Reset (any time, including mid-MUL): state IDLE, k=0, acc=0, operand regs 0, result reg 0. The in-flight operation is discarded and no out_valid is produced for it.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, c=0.
- in_ready and busy decode the state register combinationally. out_valid is a state decode (registered state, no combinational path from inputs).
- Latency, accept edge to first cycle with out_valid=1:
  - Normal: 9 MUL cycles; out_valid high from edge 9 after accept.
  - Zero-skip: out_valid high from edge 1 after accept.
- Result transfer occurs on the edge where out_valid && out_ready; in_ready high the following cycle.
- Throughput with out_ready tied high: one product per 11 cycles (accept, 9 MUL, 1 DONE).
- The 8x8 multiply path plus 48-bit add is the critical path and must close in one cycle; no multicycle constraints.

## Structure
- Shared package fpu_mul_pkg holds:
  - state enum (IDLE, MUL, DONE)
  - constants SIG_W=24, PROD_W=48, LANE_W=8, NUM_PP=9
- One sub-module: mul_8array (existing 8x8 array multiplier), instantiated once.
- Byte-select muxes and the 48-bit accumulator adder are inline. The adder may be built from CLA8 slices or a behavioural `+`.
- k counter is 4 bits.

## Test plan
- a=0xFFFFFF, b=0xFFFFFF, out_ready=1 -> c=0xFFFFFE000001, out_valid at edge 9 after accept for exactly one cycle, in_ready high the next cycle.
- a=0x800000, b=0x800000 -> c=0x400000000000; then a=0x000001, b=0xABCDEF -> c=0x000000ABCDEF. Check the previous c holds until the second result.
- Zero operand: a=0, b=0x123456:
  - SKIP_ZERO=1 -> c=0, out_valid at edge 1.
  - SKIP_ZERO=0 -> c=0, out_valid at edge 9.
- Backpressure: out_ready=0 for 6 cycles in DONE with in_valid=1 and new operands held:
  - c stable, in_ready=0, no second accept.
  - Release -> transfer, accept on the following cycle, second product correct.
- Reset pulse (rst_n low) asynchronously during MUL step k=4:
  - Outputs go to reset values immediately, without waiting for a clock edge; no out_valid for the aborted op.
  - Next op a=0x000003, b=0x000005 -> c=0x00000000000F.
- 2000 random operand pairs with random in_valid/out_ready gaps -> every c equals a*b; transfer count equals accept count; no accept while busy.

Source files
------------

// File: rtl/fpu_mul_pkg.sv
// Shared types and sizing for the sequential FPU significand multiplier.
package fpu_mul_pkg;

    localparam int unsigned SIG_W  = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned NUM_PP = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_24bit_seq_if.sv
// Operand/result handshake bundle between the FP multiply front end and normalisation.
interface mul_24bit_seq_if;
    import fpu_mul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SIG_W-1:0]  a;
    logic [SIG_W-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] c;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, busy
    );

endinterface

// File: rtl/mul_8array.sv
// Unsigned 8x8 array multiplier: sum of shifted AND rows, purely combinational.
module mul_8array (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    always_comb begin
        p = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            if (b[r]) begin
                p = p + ({8'b0, a} << r);
            end
        end
    end

endmodule

// File: rtl/mul_24bit_seq.sv
// 24x24 unsigned significand multiplier built from nine sequential 8x8 partial products.
module mul_24bit_seq
    import fpu_mul_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_24bit_seq_if.slave bus
);

    state_t            state, state_nx;
    logic [3:0]        k;
    logic [SIG_W-1:0]  a_reg, b_reg;
    logic [PROD_W-1:0] acc, res;

    logic              accept, zero_op, last_step;
    logic [1:0]        ai, bi;
    logic [5:0]        sh;
    logic [7:0]        a_lane, b_lane;
    logic [15:0]       pp;
    logic [PROD_W-1:0] pp_sh, sum;

    assign accept    = bus.in_valid && (state == IDLE);
    assign zero_op   = (bus.a == '0) || (bus.b == '0);
    assign last_step = (k == 4'(NUM_PP - 1));

    // Step k walks a-bytes slowly (i = k/3) and b-bytes quickly (j = k%3).
    assign ai     = 2'(k / 4'd3);
    assign bi     = 2'(k % 4'd3);
    assign sh     = 6'(LANE_W * (32'(ai) + 32'(bi)));
    assign a_lane = a_reg[LANE_W*ai +: LANE_W];
    assign b_lane = b_reg[LANE_W*bi +: LANE_W];

    mul_8array u_mul (
        .a (a_lane),
        .b (b_lane),
        .p (pp)
    );

    assign pp_sh = PROD_W'(pp) << sh;
    assign sum   = acc + pp_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx = (SKIP_ZERO && zero_op) ? DONE : MUL;
                end
            end
            MUL: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            res   <= '0;
        end else if (accept) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            acc   <= '0;
            k     <= '0;
            if (SKIP_ZERO && zero_op) begin
                res <= '0;
            end
        end else if (state == MUL) begin
            acc <= sum;
            k   <= k + 4'd1;
            if (last_step) begin
                res <= sum;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == MUL) || (state == DONE);
    assign bus.out_valid = (state == DONE);
    assign bus.c         = res;

endmodule
